// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity checker and its transmit-side twin.
// Holds FSM state encodings, the default frame width and the parity senses.
package serial_parity_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_BITS = 8;

    localparam bit EVEN = 1'b0;
    localparam bit ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_shift_accum.sv
// LSB-first shift register plus running XOR of every bit shifted in.
// A clear that coincides with a shift loads that bit as the first one.
module serial_parity_checker_shift_accum
    import serial_parity_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_BITS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data,
    output logic             o_acc
);

    logic [WIDTH-1:0] r_data;
    logic             r_acc;
    logic             w_first;

    assign w_first = i_bit & i_shift;

    // Bits enter at the MSB and walk down, so bit 0 lands in the LSB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
            r_acc  <= 1'b0;
        end else if (i_clr) begin
            r_data <= {w_first, {(WIDTH-1){1'b0}}};
            r_acc  <= w_first;
        end else if (i_shift) begin
            r_data <= {i_bit, r_data[WIDTH-1:1]};
            r_acc  <= r_acc ^ i_bit;
        end
    end

    assign o_data = r_data;
    assign o_acc  = r_acc;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_BITS data bits LSB first, then one parity bit.
// Define PARITY_ERR_CNT_EN to add the saturating o_err_count output.
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter bit ODD_PARITY = EVEN,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_bit_in,
    input  logic                 i_bit_valid,
    input  logic                 i_frame_start,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_frame_done,
    output logic                 o_parity_err,
    output logic                 o_busy
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] o_err_count
`endif
);

    localparam int CW = $clog2(DATA_BITS + 1);

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_next;
    logic [CW-1:0]        w_cnt_inc;
    logic                 r_err;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 w_clr;
    logic                 w_shift;
    logic                 w_load;
    logic [DATA_BITS-1:0] w_data;
    logic                 w_acc;

    serial_parity_checker_shift_accum #(
        .WIDTH (DATA_BITS)
    ) u_shift_accum (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_clr),
        .i_shift (w_shift),
        .i_bit   (i_bit_in),
        .o_data  (w_data),
        .o_acc   (w_acc)
    );

    assign w_cnt_inc = r_cnt + 1'b1;

    // frame_start wins in every state: it aborts or re-arms a frame.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_clr      = 1'b0;
        w_shift    = 1'b0;
        w_load     = 1'b0;
        if (i_frame_start) begin
            w_next     = ST_DATA;
            w_clr      = 1'b1;
            w_shift    = i_bit_valid;
            w_cnt_next = i_bit_valid ? CW'(1) : '0;
        end else begin
            unique case (r_state)
                ST_IDLE: ;
                ST_DATA: begin
                    if (i_bit_valid) begin
                        w_shift    = 1'b1;
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CW'(DATA_BITS)) begin
                            w_next = ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (i_bit_valid) begin
                        w_next = ST_DONE;
                        w_load = 1'b1;
                    end
                end
                ST_DONE: w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_load) begin
                r_err      <= i_bit_in ^ w_acc ^ ODD_PARITY;
                r_data_out <= w_data;
            end
        end
    end

    assign o_frame_done = (r_state == ST_DONE);
    assign o_parity_err = o_frame_done & r_err;
    assign o_busy       = (r_state == ST_DATA) || (r_state == ST_PARITY);
    assign o_data_out   = r_data_out;

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_cnt <= '0;
        end else if (o_parity_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_err_count = r_err_cnt;
`endif

endmodule
